// File: rtl/vending_ctrl_multi.sv
// ---------------------------------------------------------------------------
// vending_ctrl_multi
// Coin-operated vending controller with a selectable item table.
// Two coin buttons add credit, a buy button vends the item chosen by 'switch'
// when enough credit is present, and a cancel button (or an idle timeout)
// refunds whatever credit remains.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   L_button       insert coin worth COIN_L (level, edge-detected inside)
//   R_button       insert coin worth COIN_R (level, edge-detected inside)
//   C_button       cancel / refund (level, edge-detected inside)
//   B_button       buy the selected item (level, edge-detected inside)
//   switch         selected item index
//   credit         current credit
//   LED            bit i set when credit covers the price of item i
//   dispense       one-cycle pulse, item delivered
//   dispense_item  index of the delivered item, valid with dispense
//   change_valid   one-cycle pulse, change returned
//   change_amt     change amount, valid with change_valid, 0 otherwise
//   coin_reject    one-cycle pulse, coin would exceed the credit ceiling
//   deny           one-cycle pulse, buy refused
//   state          current FSM state (IDLE=0, CREDIT=1, VEND=2, CHANGE=3)
// ---------------------------------------------------------------------------
module vending_ctrl_multi #(
   parameter int N_ITEMS = 4,
   parameter int CREDIT_W = 11,
   parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {11'd400, 11'd300, 11'd200, 11'd100},
   parameter int COIN_L = 100,
   parameter int COIN_R = 500,
   parameter int CREDIT_MAX = 1000,
   parameter int TIMEOUT_CYC = 1000,
   parameter int MULTI_VEND = 0,
   localparam int SEL_W = $clog2(N_ITEMS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                L_button,
   input  logic                R_button,
   input  logic                C_button,
   input  logic                B_button,
   input  logic [SEL_W-1:0]    switch,
   output logic [CREDIT_W-1:0] credit,
   output logic [N_ITEMS-1:0]  LED,
   output logic                dispense,
   output logic [SEL_W-1:0]    dispense_item,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amt,
   output logic                coin_reject,
   output logic                deny,
   output logic [1:0]          state
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CREDIT_W:0]   COIN_L_WIDE = (CREDIT_W+1)'(COIN_L);
   localparam logic [CREDIT_W:0]   COIN_R_WIDE = (CREDIT_W+1)'(COIN_R);
   localparam logic [CREDIT_W:0]   MAX_WIDE    = (CREDIT_W+1)'(CREDIT_MAX);
   localparam logic [CREDIT_W-1:0] COIN_L_VAL  = CREDIT_W'(COIN_L);
   localparam logic [CREDIT_W-1:0] COIN_R_VAL  = CREDIT_W'(COIN_R);
   localparam logic [SEL_W:0]      N_ITEMS_VAL = (SEL_W+1)'(N_ITEMS);
   localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CREDIT = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } state_t;

   state_t cur_state, next_state;

   logic [3:0]          btn, btn_prev, rise;
   logic                armed;
   logic                ev_c, ev_b, ev_coin, coin_is_l, any_ev;
   logic [CREDIT_W:0]   coin_val, coin_sum;
   logic                coin_fits;
   logic [CREDIT_W-1:0] sel_price, vend_price, remainder;
   logic                buy_ok;
   logic [TO_W-1:0]     to_cnt;
   logic                to_hit;

   // Price lookup that returns 0 for an index outside the table instead of
   // reading past the end of PRICES.
   function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
      price_of = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (idx == SEL_W'(i)) price_of = PRICES[i*CREDIT_W +: CREDIT_W];
      end
   endfunction

   assign btn = {C_button, B_button, L_button, R_button};

   // Button edge detection. 'armed' stays low for the first clock after reset
   // so a button already held when reset releases only loads btn_prev and
   // never looks like a fresh press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_prev <= '0;
         armed    <= 1'b0;
      end else begin
         btn_prev <= btn;
         armed    <= 1'b1;
      end
   end

   // Event decode with fixed priority C > B > L > R: only the strongest
   // edge of the cycle survives, everything weaker is dropped.
   always_comb begin
      rise       = btn & ~btn_prev & {4{armed}};
      any_ev     = |rise;
      ev_c       = rise[3];
      ev_b       = rise[2] & ~rise[3];
      ev_coin    = (rise[1] | rise[0]) & ~(rise[3] | rise[2]);
      coin_is_l  = rise[1];
      coin_val   = coin_is_l ? COIN_L_WIDE : COIN_R_WIDE;
      coin_sum   = {1'b0, credit} + coin_val;
      coin_fits  = coin_sum <= MAX_WIDE;
      sel_price  = price_of(switch);
      buy_ok     = ({1'b0, switch} < N_ITEMS_VAL) && (credit >= sel_price);
      vend_price = price_of(dispense_item);
      remainder  = credit - vend_price;
      to_hit     = to_cnt == TO_LAST;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur_state <= IDLE;
      else     cur_state <= next_state;
   end

   // Next-state logic. A real event in CREDIT always wins over the timeout,
   // and VEND/CHANGE are single-cycle states that ignore all buttons.
   always_comb begin
      next_state = cur_state;
      case (cur_state)
         IDLE: begin
            if (ev_coin) next_state = CREDIT;
         end
         CREDIT: begin
            if (ev_c)                next_state = CHANGE;
            else if (ev_b && buy_ok) next_state = VEND;
            else if (!any_ev && to_hit) next_state = CHANGE;
         end
         VEND: begin
            if (MULTI_VEND != 0 && remainder != '0) next_state = CREDIT;
            else                                    next_state = CHANGE;
         end
         CHANGE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Credit, latched item, idle counter and the registered reject/deny
   // pulses. The counter is held at zero outside CREDIT so every entry into
   // CREDIT starts a fresh timeout window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit        <= '0;
         dispense_item <= '0;
         to_cnt        <= '0;
         coin_reject   <= 1'b0;
         deny          <= 1'b0;
      end else begin
         coin_reject <= 1'b0;
         deny        <= 1'b0;
         case (cur_state)
            IDLE: begin
               to_cnt <= '0;
               if (ev_coin) credit <= coin_is_l ? COIN_L_VAL : COIN_R_VAL;
               else         credit <= '0;
            end
            CREDIT: begin
               to_cnt <= any_ev ? '0 : to_cnt + 1'b1;
               if (ev_b) begin
                  if (buy_ok) dispense_item <= switch;
                  else        deny          <= 1'b1;
               end else if (ev_coin) begin
                  if (coin_fits) credit      <= coin_sum[CREDIT_W-1:0];
                  else           coin_reject <= 1'b1;
               end
            end
            VEND: begin
               to_cnt <= '0;
               credit <= remainder;
            end
            default: begin
               to_cnt <= '0;
               credit <= '0;
            end
         endcase
      end
   end

   // Moore outputs decoded from the registered state and credit.
   always_comb begin
      dispense     = cur_state == VEND;
      change_valid = (cur_state == CHANGE) && (credit != '0);
      change_amt   = change_valid ? credit : '0;
      state        = cur_state;
      LED          = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         LED[i] = credit >= PRICES[i*CREDIT_W +: CREDIT_W];
      end
   end

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// ---------------------------------------------------------------------------
// tb_vending_ctrl_multi
// Drives two controllers side by side (single-vend and multi-vend) with the
// same button presses. A transaction-level model predicts every pulse the
// controllers should emit and queues it; a monitor pops and compares each
// pulse as it appears. Credit, state and LED are also compared after every
// press has settled.
// ---------------------------------------------------------------------------
module tb_vending_ctrl_multi;

   localparam int N_ITEMS     = 4;
   localparam int CREDIT_W    = 11;
   localparam int SEL_W       = 2;
   localparam int COIN_L      = 100;
   localparam int COIN_R      = 500;
   localparam int CREDIT_MAX  = 1000;
   localparam int TIMEOUT_CYC = 1000;

   localparam int K_DISP   = 0;
   localparam int K_CHANGE = 1;
   localparam int K_REJECT = 2;
   localparam int K_DENY   = 3;

   typedef struct {
      int kind;
      int value;
   } resp_t;

   int price_tab [N_ITEMS] = '{100, 200, 300, 400};
   bit m_multi [2] = '{1'b0, 1'b1};

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic l_btn = 1'b0, r_btn = 1'b0, c_btn = 1'b0, b_btn = 1'b0;
   logic [SEL_W-1:0] sw = '0;

   logic [CREDIT_W-1:0] credit_o [2];
   logic [N_ITEMS-1:0]  led_o [2];
   logic                dispense_o [2];
   logic [SEL_W-1:0]    item_o [2];
   logic                change_valid_o [2];
   logic [CREDIT_W-1:0] change_amt_o [2];
   logic                coin_reject_o [2];
   logic                deny_o [2];
   logic [1:0]          state_o [2];

   int    checks = 0;
   int    errors = 0;
   int    m_credit [2];
   bit    m_active [2];
   resp_t exp_q0 [$];
   resp_t exp_q1 [$];

   always #5 clk = ~clk;

   vending_ctrl_multi dut0 (
      .clk(clk), .rst(rst),
      .L_button(l_btn), .R_button(r_btn), .C_button(c_btn), .B_button(b_btn),
      .switch(sw),
      .credit(credit_o[0]), .LED(led_o[0]),
      .dispense(dispense_o[0]), .dispense_item(item_o[0]),
      .change_valid(change_valid_o[0]), .change_amt(change_amt_o[0]),
      .coin_reject(coin_reject_o[0]), .deny(deny_o[0]), .state(state_o[0])
   );

   vending_ctrl_multi #(.MULTI_VEND(1)) dut1 (
      .clk(clk), .rst(rst),
      .L_button(l_btn), .R_button(r_btn), .C_button(c_btn), .B_button(b_btn),
      .switch(sw),
      .credit(credit_o[1]), .LED(led_o[1]),
      .dispense(dispense_o[1]), .dispense_item(item_o[1]),
      .change_valid(change_valid_o[1]), .change_amt(change_amt_o[1]),
      .coin_reject(coin_reject_o[1]), .deny(deny_o[1]), .state(state_o[1])
   );

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string name, input int d, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, actual, expected, $time);
      end
   endtask

   task automatic pushResp(input int d, input int kind, input int value);
      resp_t r;
      r.kind  = kind;
      r.value = value;
      if (d == 0) exp_q0.push_back(r);
      else        exp_q1.push_back(r);
   endtask

   task automatic popCompare(input int d, input int kind, input int value);
      resp_t e;
      int    qsize;
      qsize = (d == 0) ? exp_q0.size() : exp_q1.size();
      if (qsize == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpected_pulse dut%0d: got kind %0d value %0d expected none at %0t", d, kind, value, $time);
      end else begin
         if (d == 0) e = exp_q0.pop_front();
         else        e = exp_q1.pop_front();
         checkOutput("pulse_kind", d, kind, e.kind);
         checkOutput("pulse_value", d, value, e.value);
      end
   endtask

   // Reference model: one button press as a whole transaction, using the
   // price table and credit rules directly.
   task automatic modelPress(input int d, input bit c, input bit b, input bit l, input bit r, input int s);
      int coin;
      if (c) begin
         if (m_active[d]) begin
            if (m_credit[d] > 0) pushResp(d, K_CHANGE, m_credit[d]);
            m_credit[d] = 0;
            m_active[d] = 1'b0;
         end
      end else if (b) begin
         if (m_active[d]) begin
            if (s >= N_ITEMS || m_credit[d] < price_tab[s]) begin
               pushResp(d, K_DENY, 0);
            end else begin
               pushResp(d, K_DISP, s);
               m_credit[d] -= price_tab[s];
               if (!(m_multi[d] && m_credit[d] > 0)) begin
                  if (m_credit[d] > 0) pushResp(d, K_CHANGE, m_credit[d]);
                  m_credit[d] = 0;
                  m_active[d] = 1'b0;
               end
            end
         end
      end else if (l || r) begin
         coin = l ? COIN_L : COIN_R;
         if (!m_active[d]) begin
            m_credit[d] = coin;
            m_active[d] = 1'b1;
         end else if (m_credit[d] + coin <= CREDIT_MAX) begin
            m_credit[d] += coin;
         end else begin
            pushResp(d, K_REJECT, 0);
         end
      end
   endtask

   task automatic modelTimeout(input int d);
      if (m_active[d]) begin
         if (m_credit[d] > 0) pushResp(d, K_CHANGE, m_credit[d]);
         m_credit[d] = 0;
         m_active[d] = 1'b0;
      end
   endtask

   task automatic checkState();
      int led_exp;
      for (int d = 0; d < 2; d++) begin
         led_exp = 0;
         for (int i = 0; i < N_ITEMS; i++) begin
            if (m_credit[d] >= price_tab[i]) led_exp |= (1 << i);
         end
         checkOutput("credit", d, int'(credit_o[d]), m_credit[d]);
         checkOutput("state", d, int'(state_o[d]), m_active[d] ? 1 : 0);
         checkOutput("led", d, int'(led_o[d]), led_exp);
         checkOutput("change_amt_quiet", d, int'(change_amt_o[d]), 0);
      end
   endtask

   // One press: buttons high for one cycle, then three quiet cycles so both
   // controllers are back in IDLE or CREDIT. disp_n1 captures dispense one
   // cycle after the edge was sampled.
   task automatic applyStimulus(input bit c, input bit b, input bit l, input bit r, input int s,
                                output bit [1:0] disp_n1);
      @(negedge clk);
      c_btn = c; b_btn = b; l_btn = l; r_btn = r;
      sw = SEL_W'(s);
      for (int d = 0; d < 2; d++) modelPress(d, c, b, l, r, s);
      @(negedge clk);
      c_btn = 1'b0; b_btn = 1'b0; l_btn = 1'b0; r_btn = 1'b0;
      disp_n1 = {dispense_o[1], dispense_o[0]};
      repeat (3) @(negedge clk);
      checkState();
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      c_btn = 1'b0; b_btn = 1'b0; l_btn = 1'b0; r_btn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_credit[d] = 0;
         m_active[d] = 1'b0;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         checkOutput("rst_credit", d, int'(credit_o[d]), 0);
         checkOutput("rst_state", d, int'(state_o[d]), 0);
         checkOutput("rst_pulses", d,
                     int'({dispense_o[d], change_valid_o[d], coin_reject_o[d], deny_o[d]}), 0);
         checkOutput("rst_item", d, int'(item_o[d]), 0);
         checkOutput("rst_change_amt", d, int'(change_amt_o[d]), 0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Monitor: every pulse the controllers raise must match the next
   // prediction in that controller's queue.
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            if (dispense_o[d])     popCompare(d, K_DISP, int'(item_o[d]));
            if (change_valid_o[d]) popCompare(d, K_CHANGE, int'(change_amt_o[d]));
            if (coin_reject_o[d])  popCompare(d, K_REJECT, 0);
            if (deny_o[d])         popCompare(d, K_DENY, 0);
         end
      end
   end

   initial begin
      bit [1:0] disp;
      bit [3:0] pick;
      #1 rst = 1'b1;
      doReset();

      // Three small coins then buy item 2: exact payment, no change.
      applyStimulus(0, 0, 1, 0, 0, disp);
      applyStimulus(0, 0, 1, 0, 0, disp);
      applyStimulus(0, 0, 1, 0, 0, disp);
      applyStimulus(0, 1, 0, 0, 2, disp);
      checkOutput("buy_latency", 0, int'(disp[0]), 1);
      checkOutput("buy_latency", 1, int'(disp[1]), 1);

      // Large coin, buy item 1: single-vend refunds 300, multi-vend keeps it.
      doReset();
      applyStimulus(0, 0, 0, 1, 0, disp);
      applyStimulus(0, 1, 0, 0, 1, disp);
      applyStimulus(1, 0, 0, 0, 1, disp);

      // Two buys of item 0 from 500; second buy only matters for multi-vend.
      doReset();
      applyStimulus(0, 0, 0, 1, 0, disp);
      applyStimulus(0, 1, 0, 0, 0, disp);
      applyStimulus(0, 1, 0, 0, 0, disp);
      applyStimulus(1, 0, 0, 0, 0, disp);

      // Credit ceiling: 500 + 500 reaches the limit, a further coin bounces.
      doReset();
      applyStimulus(0, 0, 0, 1, 0, disp);
      applyStimulus(0, 0, 0, 1, 0, disp);
      applyStimulus(0, 0, 1, 0, 0, disp);

      // Insufficient credit for the most expensive item.
      doReset();
      applyStimulus(0, 0, 1, 0, 0, disp);
      applyStimulus(0, 1, 0, 0, 3, disp);

      // Simultaneous cancel, buy and coin: cancel wins outright.
      doReset();
      applyStimulus(0, 0, 1, 0, 0, disp);
      applyStimulus(0, 0, 1, 0, 0, disp);
      applyStimulus(0, 0, 1, 0, 0, disp);
      applyStimulus(1, 1, 1, 0, 0, disp);

      // Idle timeout refunds the credit.
      doReset();
      applyStimulus(0, 0, 1, 0, 0, disp);
      repeat (TIMEOUT_CYC - 10) @(negedge clk);
      for (int d = 0; d < 2; d++) checkOutput("pre_timeout_state", d, int'(state_o[d]), 1);
      for (int d = 0; d < 2; d++) modelTimeout(d);
      repeat (20) @(negedge clk);
      checkState();

      // Reset in the middle of a transaction drops credit silently.
      doReset();
      applyStimulus(0, 0, 0, 1, 0, disp);
      doReset();
      checkState();

      // Coin button held through reset release gives no event.
      @(negedge clk);
      rst = 1'b1;
      l_btn = 1'b1;
      for (int d = 0; d < 2; d++) begin
         m_credit[d] = 0;
         m_active[d] = 1'b0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checkState();
      l_btn = 1'b0;
      applyStimulus(0, 0, 1, 0, 0, disp);

      // Randomized presses, with an occasional reset.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 39) == 0) doReset();
         pick = 4'($urandom_range(1, 15));
         applyStimulus(pick[3], pick[2], pick[1], pick[0], int'($urandom_range(0, 3)), disp);
      end

      repeat (10) @(negedge clk);
      checkOutput("queue_drained", 0, exp_q0.size(), 0);
      checkOutput("queue_drained", 1, exp_q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
